// File: rtl/multicycle_control_pkg.sv
// ============================================================================
// Module  : multicycle_control_pkg
// Brief   : State codes, opcodes, funct codes and ALU encodings for the
//           multicycle controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package multicycle_control_pkg;

    localparam logic [3:0] c_st_rst    = 4'd0;
    localparam logic [3:0] c_st_fetch  = 4'd1;
    localparam logic [3:0] c_st_decode = 4'd2;
    localparam logic [3:0] c_st_memadr = 4'd3;
    localparam logic [3:0] c_st_memrd  = 4'd4;
    localparam logic [3:0] c_st_memwb  = 4'd5;
    localparam logic [3:0] c_st_memwr  = 4'd6;
    localparam logic [3:0] c_st_exec   = 4'd7;
    localparam logic [3:0] c_st_aluwb  = 4'd8;
    localparam logic [3:0] c_st_branch = 4'd9;
    localparam logic [3:0] c_st_jump   = 4'd10;
    localparam logic [3:0] c_st_addiex = 4'd11;
    localparam logic [3:0] c_st_addiwb = 4'd12;

    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_bne   = 6'b000101;
    localparam logic [5:0] c_op_j     = 6'b000010;
    localparam logic [5:0] c_op_addi  = 6'b001000;

    localparam logic [5:0] c_fn_add = 6'h20;
    localparam logic [5:0] c_fn_sub = 6'h22;
    localparam logic [5:0] c_fn_and = 6'h24;
    localparam logic [5:0] c_fn_or  = 6'h25;
    localparam logic [5:0] c_fn_nor = 6'h27;
    localparam logic [5:0] c_fn_slt = 6'h2A;

    localparam logic [3:0] c_alu_and = 4'b0000;
    localparam logic [3:0] c_alu_or  = 4'b0001;
    localparam logic [3:0] c_alu_add = 4'b0010;
    localparam logic [3:0] c_alu_sub = 4'b0110;
    localparam logic [3:0] c_alu_slt = 4'b0111;
    localparam logic [3:0] c_alu_nor = 4'b1100;
    localparam logic [3:0] c_alu_inv = 4'b1111;

endpackage

`default_nettype wire

// File: rtl/multicycle_control_alu_decoder.sv
// ============================================================================
// Module  : multicycle_control_alu_decoder
// Brief   : Combinational R-type funct -> ALU control decode.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control_alu_decoder
    import multicycle_control_pkg::*;
#(
    parameter int FNW = 6
) (
    input  logic [FNW-1:0] funct,
    output logic [3:0]     alu_crl
);

    // Unknown functs select an ALU op that yields zero, so a zero is written back.
    always_comb begin
        alu_crl = c_alu_inv;
        case (funct)
            c_fn_add: alu_crl = c_alu_add;
            c_fn_sub: alu_crl = c_alu_sub;
            c_fn_and: alu_crl = c_alu_and;
            c_fn_or:  alu_crl = c_alu_or;
            c_fn_nor: alu_crl = c_alu_nor;
            c_fn_slt: alu_crl = c_alu_slt;
            default:  alu_crl = c_alu_inv;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
// Module  : multicycle_control
// Brief   : Multicycle MIPS-subset main controller with memory-ready stalls.
//           Optional feature macro: CTRL_BNE_EN (adds bne via BRANCH state).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int OPW = 6,
    parameter int FNW = 6
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] opcode,
    input  logic [FNW-1:0] funct,
    input  logic           zero,
    input  logic           mem_ready,
    output logic [3:0]     ALUcrl,
    output logic           alu_src_a,
    output logic [1:0]     alu_src_b,
    output logic [1:0]     pc_src,
    output logic           pc_en,
    output logic           iord,
    output logic           mem_read,
    output logic           mem_write,
    output logic           ir_write,
    output logic           reg_dst,
    output logic           mem_to_reg,
    output logic           reg_write,
    output logic           illegal,
    output logic [3:0]     state
);

    logic [3:0] r_state;
    logic [3:0] w_next_state;
    logic [3:0] w_exec_crl;
    logic       w_illegal;
    logic       w_branch_ne;

    multicycle_control_alu_decoder #(
        .FNW     (FNW)
    ) u_alu_decoder (
        .funct   (funct),
        .alu_crl (w_exec_crl)
    );

`ifdef CTRL_BNE_EN
    // Branch sense is latched in DECODE so BRANCH does not depend on opcode timing.
    logic r_bne;

    always_ff @(posedge clk) begin
        if (rst)
            r_bne <= 1'b0;
        else if (r_state == c_st_decode)
            r_bne <= (opcode == c_op_bne);
    end

    assign w_branch_ne = r_bne;
`else
    assign w_branch_ne = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= c_st_rst;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_illegal    = 1'b0;
        case (r_state)
            c_st_rst:    w_next_state = c_st_fetch;
            c_st_fetch:  w_next_state = mem_ready ? c_st_decode : c_st_fetch;
            c_st_decode: begin
                case (opcode)
                    c_op_lw, c_op_sw: w_next_state = c_st_memadr;
                    c_op_rtype:       w_next_state = c_st_exec;
                    c_op_beq:         w_next_state = c_st_branch;
`ifdef CTRL_BNE_EN
                    c_op_bne:         w_next_state = c_st_branch;
`endif
                    c_op_j:           w_next_state = c_st_jump;
                    c_op_addi:        w_next_state = c_st_addiex;
                    default: begin
                        w_next_state = c_st_fetch;
                        w_illegal    = 1'b1;
                    end
                endcase
            end
            c_st_memadr: w_next_state = (opcode == c_op_lw) ? c_st_memrd : c_st_memwr;
            c_st_memrd:  w_next_state = mem_ready ? c_st_memwb : c_st_memrd;
            c_st_memwb:  w_next_state = c_st_fetch;
            c_st_memwr:  w_next_state = mem_ready ? c_st_fetch : c_st_memwr;
            c_st_exec:   w_next_state = c_st_aluwb;
            c_st_aluwb:  w_next_state = c_st_fetch;
            c_st_branch: w_next_state = c_st_fetch;
            c_st_jump:   w_next_state = c_st_fetch;
            c_st_addiex: w_next_state = c_st_addiwb;
            c_st_addiwb: w_next_state = c_st_fetch;
            default:     w_next_state = c_st_rst;
        endcase
    end

    always_comb begin
        ALUcrl     = c_alu_and;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        pc_en      = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        illegal    = w_illegal;
        state      = r_state;
        case (r_state)
            c_st_fetch: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ALUcrl    = c_alu_add;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
            end
            c_st_decode: begin
                alu_src_b = 2'b11;
                ALUcrl    = c_alu_add;
            end
            c_st_memadr, c_st_addiex: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                ALUcrl    = c_alu_add;
            end
            c_st_memrd: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            c_st_memwb: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            c_st_memwr: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            c_st_exec: begin
                alu_src_a = 1'b1;
                ALUcrl    = w_exec_crl;
            end
            c_st_aluwb: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            c_st_branch: begin
                alu_src_a = 1'b1;
                ALUcrl    = c_alu_sub;
                pc_src    = 2'b01;
                pc_en     = w_branch_ne ? ~zero : zero;
            end
            c_st_jump: begin
                pc_src = 2'b10;
                pc_en  = 1'b1;
            end
            c_st_addiwb: reg_write = 1'b1;
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// Module  : tb_multicycle_control
// Brief   : Self-checking bench: per-cycle comparison of all controller outputs
//           against an instruction-level reference sequence.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control;
    import multicycle_control_pkg::*;

    typedef struct packed {
        logic [3:0] st;
        logic [3:0] crl;
        logic       sa;
        logic [1:0] sb;
        logic [1:0] ps;
        logic       pe;
        logic       iord;
        logic       mr;
        logic       mw;
        logic       irw;
        logic       rd;
        logic       m2r;
        logic       rw;
        logic       ill;
    } ctl_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic [3:0] ALUcrl;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_en, iord, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, illegal;
    logic [3:0] state;
    ctl_t       act;

    int total = 0;
    int bad   = 0;

    multicycle_control #(.OPW(6), .FNW(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .ALUcrl     (ALUcrl),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_src     (pc_src),
        .pc_en      (pc_en),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .illegal    (illegal),
        .state      (state)
    );

    always #5 clk = ~clk;

    assign act = {state, ALUcrl, alu_src_a, alu_src_b, pc_src, pc_en, iord, mem_read,
                  mem_write, ir_write, reg_dst, mem_to_reg, reg_write, illegal};

    function automatic bit bne_on();
`ifdef CTRL_BNE_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [3:0] alu_of(input logic [5:0] fn);
        logic [3:0] tbl [6] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111};
        logic [5:0] fns [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
        for (int i = 0; i < 6; i++)
            if (fns[i] == fn) return tbl[i];
        return 4'b1111;
    endfunction

    function automatic bit is_bne(input logic [5:0] op);
        return (op == 6'b000101) && bne_on();
    endfunction

    function automatic bit legal(input logic [5:0] op);
        return (op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000})
               || is_bne(op);
    endfunction

    // Output word required in a given phase, straight from the per-state behaviour table.
    function automatic ctl_t exp_of(input logic [3:0] ph, input logic [5:0] op,
                                    input logic [5:0] fn, input logic z, input logic mr);
        ctl_t e = '0;
        e.st = ph;
        case (ph)
            c_st_fetch:  begin e.mr = 1; e.sb = 2'b01; e.crl = 4'b0010; e.irw = mr; e.pe = mr; end
            c_st_decode: begin e.sb = 2'b11; e.crl = 4'b0010; e.ill = !legal(op); end
            c_st_memadr: begin e.sa = 1; e.sb = 2'b10; e.crl = 4'b0010; end
            c_st_memrd:  begin e.mr = 1; e.iord = 1; end
            c_st_memwb:  begin e.rw = 1; e.m2r = 1; end
            c_st_memwr:  begin e.mw = 1; e.iord = 1; end
            c_st_exec:   begin e.sa = 1; e.crl = alu_of(fn); end
            c_st_aluwb:  begin e.rw = 1; e.rd = 1; end
            c_st_branch: begin e.sa = 1; e.crl = 4'b0110; e.ps = 2'b01; e.pe = is_bne(op) ? ~z : z; end
            c_st_jump:   begin e.ps = 2'b10; e.pe = 1; end
            c_st_addiex: begin e.sa = 1; e.sb = 2'b10; e.crl = 4'b0010; end
            c_st_addiwb: begin e.rw = 1; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic check(input string tag, input ctl_t e);
        total++;
        assert (act === e) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, act, e);
        end
    endtask

    // Drive one cycle of inputs, compare, then step past the next rising edge.
    task automatic drive_cycle(input string tag, input logic [3:0] ph, input logic [5:0] op,
                               input logic [5:0] fn, input logic z, input logic mr);
        opcode    = op;
        funct     = fn;
        zero      = z;
        mem_ready = mr;
        #1;
        check(tag, exp_of(ph, op, fn, z, mr));
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input int fs, input int ms);
        logic [3:0] ph [$];
        logic       mrq [$];
        logic       zz;
        for (int i = 0; i < fs; i++) begin ph.push_back(c_st_fetch); mrq.push_back(1'b0); end
        ph.push_back(c_st_fetch);  mrq.push_back(1'b1);
        ph.push_back(c_st_decode); mrq.push_back(1'($urandom));
        if (op == 6'b100011 || op == 6'b101011) begin
            ph.push_back(c_st_memadr); mrq.push_back(1'($urandom));
            for (int i = 0; i < ms; i++) begin
                ph.push_back(op == 6'b100011 ? c_st_memrd : c_st_memwr);
                mrq.push_back(1'b0);
            end
            ph.push_back(op == 6'b100011 ? c_st_memrd : c_st_memwr); mrq.push_back(1'b1);
            if (op == 6'b100011) begin ph.push_back(c_st_memwb); mrq.push_back(1'($urandom)); end
        end else if (op == 6'b000000) begin
            ph.push_back(c_st_exec);  mrq.push_back(1'($urandom));
            ph.push_back(c_st_aluwb); mrq.push_back(1'($urandom));
        end else if (op == 6'b000100 || is_bne(op)) begin
            ph.push_back(c_st_branch); mrq.push_back(1'($urandom));
        end else if (op == 6'b000010) begin
            ph.push_back(c_st_jump); mrq.push_back(1'($urandom));
        end else if (op == 6'b001000) begin
            ph.push_back(c_st_addiex); mrq.push_back(1'($urandom));
            ph.push_back(c_st_addiwb); mrq.push_back(1'($urandom));
        end
        for (int i = 0; i < ph.size(); i++) begin
            zz = (ph[i] == c_st_branch) ? z : 1'($urandom);
            drive_cycle(tag, ph[i], op, fn, zz, mrq[i]);
        end
    endtask

    initial begin
        logic [5:0] ops [8] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                6'b000101, 6'b000010, 6'b001000, 6'b111111};
        logic [5:0] fns [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h03};
        logic [5:0] rop, rfn;

        rst = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        drive_cycle("reset", c_st_rst, 6'd0, 6'd0, 1'b0, 1'b0);

        run_instr("r_add", 6'b000000, 6'h20, 1'b0, 0, 0);
        run_instr("lw_stall3", 6'b100011, 6'h00, 1'b0, 0, 3);
        run_instr("sw_fstall", 6'b101011, 6'h00, 1'b0, 2, 1);
        run_instr("beq_taken", 6'b000100, 6'h00, 1'b1, 0, 0);
        run_instr("beq_not", 6'b000100, 6'h00, 1'b0, 0, 0);
        run_instr("jump", 6'b000010, 6'h00, 1'b0, 0, 0);
        run_instr("addi", 6'b001000, 6'h00, 1'b0, 0, 0);
        run_instr("illegal", 6'b111111, 6'h00, 1'b0, 0, 0);
        run_instr("bne_z0", 6'b000101, 6'h00, 1'b0, 0, 0);
        run_instr("r_badfn", 6'b000000, 6'h03, 1'b0, 0, 0);

        // Abort a stalled store: two reset edges, then back to FETCH.
        drive_cycle("abort_fetch", c_st_fetch, 6'b101011, 6'h00, 1'b0, 1'b1);
        drive_cycle("abort_decode", c_st_decode, 6'b101011, 6'h00, 1'b0, 1'b0);
        drive_cycle("abort_memadr", c_st_memadr, 6'b101011, 6'h00, 1'b0, 1'b0);
        drive_cycle("abort_memwr", c_st_memwr, 6'b101011, 6'h00, 1'b0, 1'b0);
        rst = 1'b1;
        drive_cycle("abort_memwr_rst", c_st_memwr, 6'b101011, 6'h00, 1'b0, 1'b0);
        drive_cycle("abort_rst1", c_st_rst, 6'b101011, 6'h00, 1'b0, 1'b0);
        rst = 1'b0;
        drive_cycle("abort_rst2", c_st_rst, 6'b101011, 6'h00, 1'b0, 1'b1);

        for (int n = 0; n < 80; n++) begin
            rop = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
            rfn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 6)];
            run_instr("random", rop, rfn, 1'($urandom),
                      $urandom_range(0, 2), $urandom_range(0, 3));
        end
        drive_cycle("final_fetch", c_st_fetch, 6'd0, 6'd0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
